// File: rtl/alu_pkg.sv
// Shared definitions for the word-serial ALU sequencer.
// The package holds the FSM state type and the ALU opcode width.
package alu_pkg;

    localparam int ALU_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_chain_seq.sv
// Splits a wide operation into WORDS slices and feeds them LSB-first to an
// external N_WIDTH ALU, chaining the carry between slices.
module alu_chain_seq
    import alu_pkg::*;
#(
    parameter int N_WIDTH = 4,
    parameter int WORDS   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [WORDS*N_WIDTH-1:0]     cmd_a,
    input  logic [WORDS*N_WIDTH-1:0]     cmd_b,
    input  logic [ALU_SEL_W-1:0]         cmd_sel,
    input  logic                         cmd_c_in,
    output logic [N_WIDTH-1:0]           alu_a,
    output logic [N_WIDTH-1:0]           alu_b,
    output logic                         alu_c_in,
    output logic [ALU_SEL_W-1:0]         alu_sel,
    input  logic [N_WIDTH-1:0]           alu_y,
    input  logic                         alu_c_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WORDS*N_WIDTH-1:0]     res_y,
    output logic                         res_c_out
);

    localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int                WIDE_W   = WORDS * N_WIDTH;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WIDE_W-1:0]      a_q, a_d;
    logic [WIDE_W-1:0]      b_q, b_d;
    logic [ALU_SEL_W-1:0]   sel_q, sel_d;
    logic                   carry_q, carry_d;
    logic [WIDE_W-1:0]      res_q, res_d;
    logic                   cout_q, cout_d;

    logic [N_WIDTH-1:0]     aWord;
    logic [N_WIDTH-1:0]     bWord;

    // Constant-index word mux keeps every select in range for any WORDS.
    always_comb begin
        aWord = '0;
        bWord = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                aWord = a_q[w*N_WIDTH +: N_WIDTH];
                bWord = b_q[w*N_WIDTH +: N_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        carry_d   = carry_q;
        res_d     = res_q;
        cout_d    = cout_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_c_in  = 1'b0;
        alu_sel   = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_sel;
                    carry_d = cmd_c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                alu_a    = aWord;
                alu_b    = bWord;
                alu_c_in = carry_q;
                alu_sel  = sel_q;
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        res_d[w*N_WIDTH +: N_WIDTH] = alu_y;
                    end
                end
                // The result carry is kept apart from carry_q so acceptance of
                // a new command cannot disturb the previous res_c_out.
                carry_d = alu_c_out;
                cout_d  = alu_c_out;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
        end
    end

    assign res_y     = res_q;
    assign res_c_out = cout_q;

endmodule

// File: doc/alu_chain_seq.md
ALU_CHAIN_SEQ -- requirements
Module: alu_chain_seq

Interface
REQ-001 SHALL have parameter N_WIDTH, default 4, which is the datapath width of the downstream ALU slice.
REQ-002 SHALL have parameter WORDS, default 4 (legal range >=1), which is the number of N_WIDTH slices per wide operation.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, width 1: command present.
REQ-006 SHALL have port cmd_ready, output, width 1: command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-007 SHALL have ports cmd_a and cmd_b, input, width WORDS*N_WIDTH each: wide operands, with word 0 in the LSBs.
REQ-008 SHALL have port cmd_sel, input, width 3: ALU operation code, opaque to this block.
REQ-009 SHALL have port cmd_c_in, input, width 1: carry into word 0.
REQ-010 SHALL have ports alu_a and alu_b, output, width N_WIDTH each: slice operands to the ALU.
REQ-011 SHALL have ports alu_c_in (output, width 1) and alu_sel (output, width 3) to the ALU.
REQ-012 SHALL have ports alu_y (input, width N_WIDTH) and alu_c_out (input, width 1): combinational ALU result.
REQ-013 SHALL have ports res_valid (output, width 1) and res_ready (input, width 1): result handshake.
REQ-014 SHALL have ports res_y (output, width WORDS*N_WIDTH) and res_c_out (output, width 1): wide result and final carry.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE, SHALL drive cmd_ready=1; in RUN and DONE, SHALL drive cmd_ready=0 (cmd_ready = state==IDLE).
REQ-017 On acceptance, SHALL register cmd_a, cmd_b, cmd_sel and cmd_c_in (as carry_reg), clear word index idx to 0, and go to RUN; later changes on cmd_* SHALL have no effect.
REQ-018 In RUN, SHALL drive alu_a=a_reg word idx, alu_b=b_reg word idx, alu_c_in=carry_reg and alu_sel=sel_reg.
REQ-019 In RUN, each edge SHALL store alu_y into res word idx, load carry_reg with alu_c_out, and increment idx.
REQ-020 Carry chaining per REQ-019 SHALL apply for every sel value.
REQ-021 From RUN, SHALL go to DONE on the edge where idx==WORDS-1; for WORDS=1, RUN SHALL last exactly one cycle.
REQ-022 Latency: acceptance at edge t, RUN during cycles t+1..t+WORDS, res_valid high from the cycle after edge t+WORDS.
REQ-023 In DONE, SHALL hold res_valid=1 with res_y and res_c_out (= final carry_reg) stable until res_ready=1 at an edge, then go to IDLE.
REQ-024 SHALL NOT accept a new command in the same cycle a result is handed off; peak throughput is one command per WORDS+2 cycles.
REQ-025 Outside RUN, SHALL drive alu_a, alu_b, alu_c_in and alu_sel to 0.
REQ-026 res_y and res_c_out SHALL retain their last value after handoff until the next RUN overwrites them.
REQ-027 Whenever cmd_ready=0, cmd_valid SHALL be ignored with no state change.

Reset
REQ-028 While rst_n=0, SHALL force state=IDLE, idx=0, and all operand, carry and result registers to 0.
REQ-029 While rst_n=0, res_valid SHALL be 0, alu_* outputs SHALL be 0, and cmd_ready SHALL be 1.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation; no res_valid pulse SHALL follow for the aborted command.
REQ-031 SHALL have no undefined output values after the first rst_n assertion.

Structure
REQ-032 A shared package alu_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constant ALU_SEL_W=3.
REQ-033 No sub-module SHALL be used; the ALU SHALL stay external, connected via the alu_* ports.
REQ-034 idx width SHALL be clog2(WORDS), minimum 1.

Verification (bench ALU stub: y,c_out = a+b+c_in; N_WIDTH=4, WORDS=4)
REQ-035 SHALL verify: cmd_a=16'hFFFF, cmd_b=16'h0001, c_in=0 accepted at edge t -> res_valid rises after edge t+4, res_y=16'h0000, res_c_out=1.
REQ-036 SHALL verify: cmd_a=16'h1234, cmd_b=16'h0F0F, c_in=1, sel=3'd5 -> alu_sel=5 and alu_a sequence 4,3,2,1 in RUN, res_y=16'h2144, res_c_out=0.
REQ-037 SHALL verify: res_ready held low 10 cycles in DONE -> res_valid and res_y stable throughout, cmd_ready=0, and a cmd_valid pulse is ignored.
REQ-038 SHALL verify: rst_n pulsed low during the 2nd RUN cycle -> immediate IDLE, all outputs 0, cmd_ready=1, and no res_valid afterwards.
REQ-039 SHALL verify: back-to-back commands with res_ready=1 -> acceptances spaced exactly 6 cycles apart (WORDS+2) with correct results.
REQ-040 SHALL verify: WORDS=1 build, a=4'hF, b=4'h1, c_in=1 -> res_y=4'h1, res_c_out=1, res_valid two cycles after acceptance.
